// File: rtl/stream_scheduler.sv
// Purpose : arbitrates up to four tx message sources onto the single framer stream;
//           stream 0 has burst-limited priority, streams 1..N-1 share round-robin.
// Latency : 1 cycle src_avail -> strm_avail; bytes pass through with 0 cycles (pull and data are combinational).
// Backpres: the framer paces everything: a message is held in OFFER until strm_start, bytes move only on strm_pull.
// Ports   : clk/rst_n (sync, active-low); src_data/src_count/src_avail/src_pull per source;
//           strm_data/strm_count/strm_id/strm_avail/strm_start/strm_pull to the framer; busy = grant held.
module stream_scheduler #(
  parameter int NSTREAMS   = 4,
  parameter int RESP_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*NSTREAMS-1:0]    src_data,
  input  logic [10*NSTREAMS-1:0]   src_count,
  input  logic [NSTREAMS-1:0]      src_avail,
  output logic [NSTREAMS-1:0]      src_pull,
  output logic [7:0]               strm_data,
  output logic [9:0]               strm_count,
  output logic [3:0]               strm_id,
  output logic                     strm_avail,
  input  logic                     strm_start,
  input  logic                     strm_pull,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  sel;
  logic [1:0]  rr_ptr;
  logic [3:0]  burst_cnt;
  logic [9:0]  remaining;
  // Whether a competing stream was waiting when stream 0 won; decides
  // whether its completion counts toward the burst limit.
  logic        other_at_grant;

  // ---------------- arbitration ----------------
  logic        others_avail;
  logic        win_vld;
  logic [1:0]  win_idx;
  logic [2:0]  cand;

  always_comb begin
    others_avail = |src_avail[NSTREAMS-1:1];
    win_vld      = 1'b0;
    win_idx      = 2'd0;
    cand         = 3'd0;
    if (src_avail[0] && ((burst_cnt < 4'(RESP_BURST)) || !others_avail)) begin
      win_vld = 1'b1;
      win_idx = 2'd0;
    end else begin
      // Scan rr_ptr, rr_ptr+1, ... wrapping inside 1..NSTREAMS-1.
      for (int k = 0; k < NSTREAMS-1; k++) begin
        cand = {1'b0, rr_ptr} + 3'(k);
        if (cand > 3'(NSTREAMS-1)) cand = cand - 3'(NSTREAMS-1);
        if (!win_vld && src_avail[cand[1:0]]) begin
          win_vld = 1'b1;
          win_idx = cand[1:0];
        end
      end
    end
  end

  // ---------------- completion bookkeeping ----------------
  logic [3:0] burst_done;
  logic [1:0] rr_done;

  always_comb begin
    burst_done = 4'd0;
    rr_done    = rr_ptr;
    if (sel == 2'd0) begin
      if (other_at_grant)
        burst_done = (burst_cnt >= 4'(RESP_BURST)) ? 4'(RESP_BURST) : 4'(burst_cnt + 4'd1);
    end else begin
      rr_done = (sel >= 2'(NSTREAMS-1)) ? 2'd1 : 2'(sel + 2'd1);
    end
  end

  // ---------------- datapath ----------------
  assign strm_data = src_data[{sel, 3'b000} +: 8];

  always_comb begin
    src_pull = '0;
    if (state == SEND && strm_pull) src_pull[sel] = 1'b1;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      sel            <= 2'd0;
      strm_avail     <= 1'b0;
      strm_id        <= 4'd0;
      strm_count     <= 10'd0;
      busy           <= 1'b0;
      rr_ptr         <= 2'd1;
      burst_cnt      <= 4'd0;
      remaining      <= 10'd0;
      other_at_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            sel            <= win_idx;
            strm_id        <= {2'b00, win_idx};
            strm_count     <= src_count[int'(win_idx)*10 +: 10];
            other_at_grant <= others_avail;
            strm_avail     <= 1'b1;
            busy           <= 1'b1;
            state          <= OFFER;
          end
        end
        OFFER: begin
          if (!src_avail[sel]) begin
            // Source retracted: drop the offer, leave fairness state alone.
            strm_avail <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (strm_start) begin
            remaining  <= strm_count;
            strm_avail <= 1'b0;
            if (strm_count == 10'd0) begin
              busy      <= 1'b0;
              burst_cnt <= burst_done;
              rr_ptr    <= rr_done;
              state     <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        SEND: begin
          if (strm_pull) begin
            if (remaining != 10'd0) remaining <= remaining - 10'd1;
            if (remaining == 10'd1) begin
              busy      <= 1'b0;
              burst_cnt <= burst_done;
              rr_ptr    <= rr_done;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_scheduler.sv
module tb_stream_scheduler;

  logic        clk;
  logic        rst_n;
  logic [31:0] src_data;
  logic [39:0] src_count;
  logic [3:0]  src_avail;
  logic [3:0]  src_pull;
  logic [7:0]  strm_data;
  logic [9:0]  strm_count;
  logic [3:0]  strm_id;
  logic        strm_avail;
  logic        strm_start;
  logic        strm_pull;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] gid;
  logic [7:0] bytes_a [3] = '{8'hA1, 8'hB2, 8'hC3};
  int         exp_rr  [6] = '{1, 2, 3, 1, 2, 3};
  int         exp_pri [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int         pulls;

  stream_scheduler #(.NSTREAMS(4), .RESP_BURST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .src_count  (src_count),
    .src_avail  (src_avail),
    .src_pull   (src_pull),
    .strm_data  (strm_data),
    .strm_count (strm_count),
    .strm_id    (strm_id),
    .strm_avail (strm_avail),
    .strm_start (strm_start),
    .strm_pull  (strm_pull),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for an offer, accept it, and pull exp_n bytes.
  task automatic run_msg(input int exp_n, output logic [3:0] id);
    int   waited;
    int   bad;
    logic busy_mid;
    waited = 0;
    while (strm_avail !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    chk("offer_seen", {31'd0, strm_avail}, 32'd1);
    chk("offer_count", {22'd0, strm_count}, 32'(exp_n));
    id = strm_id;
    strm_start = 1'b1;
    step();
    strm_start = 1'b0;
    bad      = 0;
    busy_mid = 1'b1;
    for (int i = 0; i < exp_n; i++) begin
      strm_pull = 1'b1;
      #1;
      if (src_pull !== 4'(1 << id)) bad++;
      if (busy !== 1'b1) busy_mid = 1'b0;
      step();
    end
    strm_pull = 1'b0;
    chk("pull_routing", 32'(bad), 32'd0);
    chk("busy_during_msg", {31'd0, busy_mid}, 32'd1);
    chk("busy_after_msg", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    src_data   = '0;
    src_count  = '0;
    src_avail  = '0;
    strm_start = 1'b0;
    strm_pull  = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // ---- reset state ----
    chk("rst_strm_avail", {31'd0, strm_avail}, 32'd0);
    chk("rst_strm_id", {28'd0, strm_id}, 32'd0);
    chk("rst_strm_count", {22'd0, strm_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_src_pull", {28'd0, src_pull}, 32'd0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    chk("rst_burst_cnt", 32'(dut.burst_cnt), 32'd0);
    chk("rst_remaining", 32'(dut.remaining), 32'd0);

    // ---- round-robin among 1,2,3 ----
    src_count = {10'd2, 10'd2, 10'd2, 10'd2};
    src_avail = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      run_msg(2, gid);
      chk($sformatf("rr_grant_%0d", i), {28'd0, gid}, 32'(exp_rr[i]));
    end
    src_avail = 4'b0000;
    chk("rr_ptr_wrap", 32'(dut.rr_ptr), 32'd1);
    step();

    // ---- single stream, data A,B,C ----
    src_count[19:10] = 10'd3;
    src_data[15:8]   = bytes_a[0];
    src_avail        = 4'b0010;
    step();
    chk("single_avail", {31'd0, strm_avail}, 32'd1);
    chk("single_id", {28'd0, strm_id}, 32'd1);
    chk("single_count", {22'd0, strm_count}, 32'd3);
    chk("single_busy", {31'd0, busy}, 32'd1);
    strm_start = 1'b1;
    step();
    strm_start = 1'b0;
    chk("single_send_state", 32'(dut.state), 32'd2);
    chk("single_avail_low", {31'd0, strm_avail}, 32'd0);
    pulls = 0;
    for (int i = 0; i < 3; i++) begin
      src_data[15:8] = bytes_a[i];
      strm_pull = 1'b1;
      #1;
      if (src_pull[1] === 1'b1) pulls++;
      chk($sformatf("single_src_pull_%0d", i), {28'd0, src_pull}, 32'h2);
      chk($sformatf("single_data_%0d", i), {24'd0, strm_data}, {24'd0, bytes_a[i]});
      step();
    end
    strm_pull = 1'b0;
    src_avail = 4'b0000;
    chk("single_pull_total", 32'(pulls), 32'd3);
    chk("single_busy_drop", {31'd0, busy}, 32'd0);
    chk("single_idle", 32'(dut.state), 32'd0);
    chk("single_rr_ptr", 32'(dut.rr_ptr), 32'd2);
    // stray pull in IDLE
    strm_pull = 1'b1;
    #1;
    chk("stray_idle_pull", {28'd0, src_pull}, 32'd0);
    step();
    strm_pull = 1'b0;
    chk("stray_idle_busy", {31'd0, busy}, 32'd0);

    // ---- priority with burst limit ----
    src_count = {10'd2, 10'd2, 10'd2, 10'd2};
    src_avail = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      run_msg(2, gid);
      chk($sformatf("pri_grant_%0d", i), {28'd0, gid}, 32'(exp_pri[i]));
      if (i == 3) chk("pri_burst_sat", 32'(dut.burst_cnt), 32'd4);
    end
    src_avail = 4'b0000;
    chk("pri_burst_clear", 32'(dut.burst_cnt), 32'd0);
    step();

    // ---- zero-length message ----
    src_count[9:0] = 10'd0;
    src_avail      = 4'b0001;
    run_msg(0, gid);
    src_avail = 4'b0000;
    chk("zero_id", {28'd0, gid}, 32'd0);
    chk("zero_idle", 32'(dut.state), 32'd0);
    chk("zero_remaining", 32'(dut.remaining), 32'd0);
    step();

    // ---- maximum-length message ----
    src_count[9:0] = 10'd1023;
    src_avail      = 4'b0001;
    run_msg(1023, gid);
    src_avail = 4'b0000;
    chk("max_id", {28'd0, gid}, 32'd0);
    chk("max_remaining", 32'(dut.remaining), 32'd0);
    chk("max_idle", 32'(dut.state), 32'd0);
    step();

    // ---- stray pull in OFFER, then retract ----
    src_count[29:20] = 10'd5;
    src_avail        = 4'b0100;
    step();
    chk("retract_offer_id", {28'd0, strm_id}, 32'd2);
    strm_pull = 1'b1;
    #1;
    chk("stray_offer_pull", {28'd0, src_pull}, 32'd0);
    step();
    strm_pull = 1'b0;
    chk("stray_offer_state", 32'(dut.state), 32'd1);
    src_avail = 4'b0000;
    step();
    chk("retract_avail", {31'd0, strm_avail}, 32'd0);
    chk("retract_busy", {31'd0, busy}, 32'd0);
    chk("retract_idle", 32'(dut.state), 32'd0);
    chk("retract_rr_ptr", 32'(dut.rr_ptr), 32'd2);
    chk("retract_burst", 32'(dut.burst_cnt), 32'd0);

    // ---- start+pull together, then reset mid-SEND ----
    src_count[39:30] = 10'd5;
    src_avail        = 4'b1000;
    step();
    chk("rst_t_id", {28'd0, strm_id}, 32'd3);
    chk("rst_t_count", {22'd0, strm_count}, 32'd5);
    strm_start = 1'b1;
    strm_pull  = 1'b1;
    #1;
    chk("start_pull_no_src", {28'd0, src_pull}, 32'd0);
    step();
    strm_start = 1'b0;
    strm_pull  = 1'b0;
    chk("start_pull_send", 32'(dut.state), 32'd2);
    chk("start_pull_remaining", 32'(dut.remaining), 32'd5);
    for (int i = 0; i < 2; i++) begin
      strm_pull = 1'b1;
      #1;
      chk($sformatf("rst_t_pull_%0d", i), {28'd0, src_pull}, 32'h8);
      step();
    end
    strm_pull = 1'b0;
    chk("rst_t_remaining", 32'(dut.remaining), 32'd3);
    rst_n     = 1'b0;
    src_avail = 4'b0000;
    step();
    rst_n = 1'b1;
    chk("mid_rst_avail", {31'd0, strm_avail}, 32'd0);
    chk("mid_rst_id", {28'd0, strm_id}, 32'd0);
    chk("mid_rst_count", {22'd0, strm_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_src_pull", {28'd0, src_pull}, 32'd0);
    chk("mid_rst_rr_ptr", 32'(dut.rr_ptr), 32'd1);
    chk("mid_rst_burst", 32'(dut.burst_cnt), 32'd0);
    chk("mid_rst_remaining", 32'(dut.remaining), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'd0);
    strm_pull = 1'b1;
    #1;
    chk("post_rst_pull_a", {28'd0, src_pull}, 32'd0);
    step();
    chk("post_rst_pull_b", {28'd0, src_pull}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    strm_pull = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
